prediction_stat_table: RTL and testbench

//  Per-branch-slot storage for the statistics and trend counters of the three predictors
//  (SP static, LHP local history, GHP global history).

---
 rtl/prediction_stat_table.sv | 128 ++++++++++++
 tb/tb_prediction_stat_table.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/prediction_stat_table.sv
// prediction_stat_table: per-slot stat/trend counters for SP, LHP and GHP with write bypass and predictor choice.
module prediction_stat_table #(
    parameter int JUMP_STATUS_COUNTER_WIDTH = 2,
    parameter int STAT_COUNTER_WIDTH        = 5
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear_en1_i,
    input  logic                                 clear_en2_i,
    input  logic [2:0]                           wr_addr1_i,
    input  logic [2:0]                           wr_addr2_i,
    input  logic                                 wr_sp_stat_en1_i,
    input  logic                                 wr_sp_stat_en2_i,
    input  logic                                 wr_sp_trend_en1_i,
    input  logic                                 wr_sp_trend_en2_i,
    input  logic                                 wr_sp_index1_i,
    input  logic                                 wr_sp_index2_i,
    input  logic [STAT_COUNTER_WIDTH-1:0]        wr_sp_stat_count1_i,
    input  logic [STAT_COUNTER_WIDTH-1:0]        wr_sp_stat_count2_i,
    input  logic [2:0]                           wr_sp_trend_count1_i,
    input  logic [2:0]                           wr_sp_trend_count2_i,
    input  logic                                 wr_lhp_stat_en1_i,
    input  logic                                 wr_lhp_stat_en2_i,
    input  logic                                 wr_lhp_trend_en1_i,
    input  logic                                 wr_lhp_trend_en2_i,
    input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] wr_lhp_index1_i,
    input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] wr_lhp_index2_i,
    input  logic [STAT_COUNTER_WIDTH-1:0]        wr_lhp_stat_count1_i,
    input  logic [STAT_COUNTER_WIDTH-1:0]        wr_lhp_stat_count2_i,
    input  logic [2:0]                           wr_lhp_trend_count1_i,
    input  logic [2:0]                           wr_lhp_trend_count2_i,
    input  logic                                 wr_ghp_stat_en1_i,
    input  logic                                 wr_ghp_stat_en2_i,
    input  logic                                 wr_ghp_trend_en1_i,
    input  logic                                 wr_ghp_trend_en2_i,
    input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] wr_ghp_index1_i,
    input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] wr_ghp_index2_i,
    input  logic [STAT_COUNTER_WIDTH-1:0]        wr_ghp_stat_count1_i,
    input  logic [STAT_COUNTER_WIDTH-1:0]        wr_ghp_stat_count2_i,
    input  logic [2:0]                           wr_ghp_trend_count1_i,
    input  logic [2:0]                           wr_ghp_trend_count2_i,
    input  logic [2:0]                           rd_addr_i,
    input  logic                                 rd_sp_index_i,
    input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] rd_lhp_index_i,
    input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] rd_ghp_index_i,
    output logic [STAT_COUNTER_WIDTH-1:0]        rd_sp_stat_count_o,
    output logic [2:0]                           rd_sp_trend_count_o,
    output logic [STAT_COUNTER_WIDTH-1:0]        rd_lhp_stat_count_o,
    output logic [2:0]                           rd_lhp_trend_count_o,
    output logic [STAT_COUNTER_WIDTH-1:0]        rd_ghp_stat_count_o,
    output logic [2:0]                           rd_ghp_trend_count_o,
    output logic [1:0]                           pred_sel_o
);
    localparam int IW  = JUMP_STATUS_COUNTER_WIDTH;
    localparam int SCW = STAT_COUNTER_WIDTH;
    localparam int NS  = 1 << IW;
    localparam logic [SCW+2:0] FLIP = {1'b1, {(SCW-1){1'b0}}, 3'b100};
    logic [SCW-1:0] stat_q  [3][8][NS];
    logic [2:0]     trend_q [3][8][NS];
    logic [1:0]                ce;
    logic [1:0][2:0]           wa;
    logic [1:0][2:0]           se, te;
    logic [1:0][2:0][IW-1:0]   wi;
    logic [1:0][2:0][SCW-1:0]  ws;
    logic [1:0][2:0][2:0]      wt;
    logic [2:0][IW-1:0]        ri;
    logic [2:0][SCW-1:0]       rs;
    logic [2:0][2:0]           rt;
    logic [2:0][SCW+2:0]       k;
    logic                      lhp_gt_ghp;
    // Ports and predictors packed as [port][predictor], predictor 0=SP, 1=LHP, 2=GHP.
    assign ce = {clear_en2_i, clear_en1_i};
    assign wa = {wr_addr2_i, wr_addr1_i};
    assign se = {wr_ghp_stat_en2_i, wr_lhp_stat_en2_i, wr_sp_stat_en2_i,
                 wr_ghp_stat_en1_i, wr_lhp_stat_en1_i, wr_sp_stat_en1_i};
    assign te = {wr_ghp_trend_en2_i, wr_lhp_trend_en2_i, wr_sp_trend_en2_i,
                 wr_ghp_trend_en1_i, wr_lhp_trend_en1_i, wr_sp_trend_en1_i};
    assign wi = {wr_ghp_index2_i, wr_lhp_index2_i, IW'(wr_sp_index2_i),
                 wr_ghp_index1_i, wr_lhp_index1_i, IW'(wr_sp_index1_i)};
    assign ws = {wr_ghp_stat_count2_i, wr_lhp_stat_count2_i, wr_sp_stat_count2_i,
                 wr_ghp_stat_count1_i, wr_lhp_stat_count1_i, wr_sp_stat_count1_i};
    assign wt = {wr_ghp_trend_count2_i, wr_lhp_trend_count2_i, wr_sp_trend_count2_i,
                 wr_ghp_trend_count1_i, wr_lhp_trend_count1_i, wr_sp_trend_count1_i};
    assign ri = {rd_ghp_index_i, rd_lhp_index_i, IW'(rd_sp_index_i)};
    // Later assignments win, giving clear > port 2 > port 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (stat_q[p, a, s]) begin
                stat_q[p][a][s]  <= '0;
                trend_q[p][a][s] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++)
                for (int p = 0; p < 3; p++) begin
                    if (se[n][p]) stat_q[p][wa[n]][wi[n][p]] <= ws[n][p];
                    if (te[n][p]) trend_q[p][wa[n]][wi[n][p]] <= wt[n][p];
                end
            for (int n = 0; n < 2; n++)
                if (ce[n])
                    for (int p = 0; p < 3; p++)
                        for (int s = 0; s < NS; s++) stat_q[p][wa[n]][s] <= '0;
        end
    end
    // Bypass mirrors the commit priority so reads show the post-edge value; gated off in reset.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rs[p] = stat_q[p][rd_addr_i][ri[p]];
            rt[p] = trend_q[p][rd_addr_i][ri[p]];
            for (int n = 0; n < 2; n++)
                if (!rst && wa[n] == rd_addr_i && wi[n][p] == ri[p]) begin
                    if (se[n][p]) rs[p] = ws[n][p];
                    if (te[n][p]) rt[p] = wt[n][p];
                end
            for (int n = 0; n < 2; n++)
                if (!rst && ce[n] && wa[n] == rd_addr_i) rs[p] = '0;
            k[p] = {rs[p], rt[p]} ^ FLIP;
        end
    end
    // Sign-flipped {stat,trend} keys order lexicographically as unsigned values.
    assign lhp_gt_ghp = k[1] > k[2];
    assign pred_sel_o = (k[0] > (lhp_gt_ghp ? k[1] : k[2])) ? 2'b00 : lhp_gt_ghp ? 2'b01 : 2'b10;
    assign rd_sp_stat_count_o   = rs[0];
    assign rd_lhp_stat_count_o  = rs[1];
    assign rd_ghp_stat_count_o  = rs[2];
    assign rd_sp_trend_count_o  = rt[0];
    assign rd_lhp_trend_count_o = rt[1];
    assign rd_ghp_trend_count_o = rt[2];
endmodule

// File: tb/tb_prediction_stat_table.sv
// tb_prediction_stat_table: random and directed stimulus checked against an array-based reference model.
module tb_prediction_stat_table;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       b_ce [2];
    logic [2:0] b_wa [2];
    logic       b_se [2][3];
    logic       b_te [2][3];
    logic [1:0] b_wi [2][3];
    logic [4:0] b_ws [2][3];
    logic [2:0] b_wt [2][3];
    logic [2:0] b_ra;
    logic [1:0] b_ri [3];
    logic [4:0] a_s [3];
    logic [2:0] a_t [3];
    logic [1:0] a_sel;

    logic [4:0] m_s [3][8][4];
    logic [4:0] n_s [3][8][4];
    logic [2:0] m_t [3][8][4];
    logic [2:0] n_t [3][8][4];
    int vecs = 0;
    int errs = 0;

    prediction_stat_table dut (
        .clk(clk), .rst(rst),
        .clear_en1_i(b_ce[0]), .clear_en2_i(b_ce[1]),
        .wr_addr1_i(b_wa[0]), .wr_addr2_i(b_wa[1]),
        .wr_sp_stat_en1_i(b_se[0][0]), .wr_sp_stat_en2_i(b_se[1][0]),
        .wr_sp_trend_en1_i(b_te[0][0]), .wr_sp_trend_en2_i(b_te[1][0]),
        .wr_sp_index1_i(b_wi[0][0][0]), .wr_sp_index2_i(b_wi[1][0][0]),
        .wr_sp_stat_count1_i(b_ws[0][0]), .wr_sp_stat_count2_i(b_ws[1][0]),
        .wr_sp_trend_count1_i(b_wt[0][0]), .wr_sp_trend_count2_i(b_wt[1][0]),
        .wr_lhp_stat_en1_i(b_se[0][1]), .wr_lhp_stat_en2_i(b_se[1][1]),
        .wr_lhp_trend_en1_i(b_te[0][1]), .wr_lhp_trend_en2_i(b_te[1][1]),
        .wr_lhp_index1_i(b_wi[0][1]), .wr_lhp_index2_i(b_wi[1][1]),
        .wr_lhp_stat_count1_i(b_ws[0][1]), .wr_lhp_stat_count2_i(b_ws[1][1]),
        .wr_lhp_trend_count1_i(b_wt[0][1]), .wr_lhp_trend_count2_i(b_wt[1][1]),
        .wr_ghp_stat_en1_i(b_se[0][2]), .wr_ghp_stat_en2_i(b_se[1][2]),
        .wr_ghp_trend_en1_i(b_te[0][2]), .wr_ghp_trend_en2_i(b_te[1][2]),
        .wr_ghp_index1_i(b_wi[0][2]), .wr_ghp_index2_i(b_wi[1][2]),
        .wr_ghp_stat_count1_i(b_ws[0][2]), .wr_ghp_stat_count2_i(b_ws[1][2]),
        .wr_ghp_trend_count1_i(b_wt[0][2]), .wr_ghp_trend_count2_i(b_wt[1][2]),
        .rd_addr_i(b_ra), .rd_sp_index_i(b_ri[0][0]),
        .rd_lhp_index_i(b_ri[1]), .rd_ghp_index_i(b_ri[2]),
        .rd_sp_stat_count_o(a_s[0]), .rd_sp_trend_count_o(a_t[0]),
        .rd_lhp_stat_count_o(a_s[1]), .rd_lhp_trend_count_o(a_t[1]),
        .rd_ghp_stat_count_o(a_s[2]), .rd_ghp_trend_count_o(a_t[2]),
        .pred_sel_o(a_sel)
    );

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic idle();
        for (int n = 0; n < 2; n++) begin
            b_ce[n] = 1'b0;
            b_wa[n] = 3'd0;
            for (int p = 0; p < 3; p++) begin
                b_se[n][p] = 1'b0; b_te[n][p] = 1'b0; b_wi[n][p] = 2'd0;
                b_ws[n][p] = 5'd0; b_wt[n][p] = 3'd0;
            end
        end
        b_ra = 3'd0;
        for (int p = 0; p < 3; p++) b_ri[p] = 2'd0;
    endtask

    task automatic zero_model();
        foreach (m_s[p, a, s]) begin
            m_s[p][a][s] = 5'd0;
            m_t[p][a][s] = 3'd0;
        end
    endtask

    // The state after this edge: port 1, then port 2, then clears override.
    task automatic model_next();
        n_s = m_s;
        n_t = m_t;
        for (int n = 0; n < 2; n++)
            for (int p = 0; p < 3; p++) begin
                if (b_se[n][p]) n_s[p][b_wa[n]][b_wi[n][p]] = b_ws[n][p];
                if (b_te[n][p]) n_t[p][b_wa[n]][b_wi[n][p]] = b_wt[n][p];
            end
        for (int n = 0; n < 2; n++)
            if (b_ce[n])
                for (int p = 0; p < 3; p++)
                    for (int s = 0; s < 4; s++) n_s[p][b_wa[n]][s] = 5'd0;
    endtask

    task automatic settle_check();
        logic [4:0] es [3];
        logic [2:0] et [3];
        int best;
        #2;
        model_next();
        for (int p = 0; p < 3; p++) begin
            es[p] = n_s[p][b_ra][b_ri[p]];
            et[p] = n_t[p][b_ra][b_ri[p]];
            chk($sformatf("stat_p%0d", p), a_s[p], es[p]);
            chk($sformatf("trend_p%0d", p), a_t[p], et[p]);
        end
        best = 2;
        for (int p = 1; p >= 0; p--)
            if ($signed(es[p]) > $signed(es[best]) ||
                ($signed(es[p]) == $signed(es[best]) && $signed(et[p]) > $signed(et[best])))
                best = p;
        chk("pred_sel", a_sel, best);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        m_s = n_s;
        m_t = n_t;
    endtask

    task automatic rand_in();
        for (int n = 0; n < 2; n++) begin
            b_ce[n] = ($urandom_range(0, 9) == 0);
            b_wa[n] = 3'($urandom_range(0, 7));
            for (int p = 0; p < 3; p++) begin
                b_se[n][p] = ($urandom_range(0, 2) == 0);
                b_te[n][p] = ($urandom_range(0, 2) == 0);
                b_wi[n][p] = (p == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
                b_ws[n][p] = 5'($urandom);
                b_wt[n][p] = 3'($urandom);
            end
        end
        if ($urandom_range(0, 2) == 0) b_wa[1] = b_wa[0];
        b_ra = ($urandom_range(0, 1) == 1) ? b_wa[$urandom_range(0, 1)] : 3'($urandom_range(0, 7));
        for (int p = 0; p < 3; p++)
            b_ri[p] = ($urandom_range(0, 1) == 1) ? b_wi[$urandom_range(0, 1)][p]
                    : (p == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
    endtask

    task automatic reset_outputs_chk(input string tag);
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("%s_stat_p%0d", tag, p), a_s[p], 0);
            chk($sformatf("%s_trend_p%0d", tag, p), a_t[p], 0);
        end
        chk($sformatf("%s_pred_sel", tag), a_sel, 2);
    endtask

    initial begin
        idle();
        zero_model();
        #3;
        reset_outputs_chk("rst_init");
        @(posedge clk);
        #1;
        rst = 1'b0;
        settle_check();
        chk("post_rst_sel", a_sel, 2);
        advance();

        idle(); b_se[1][1] = 1; b_wa[1] = 5; b_wi[1][1] = 3; b_ws[1][1] = 5'd7; b_ra = 5; b_ri[1] = 3;
        settle_check(); chk("single_bypass", a_s[1], 7); advance();
        idle(); b_ra = 5; b_ri[1] = 3;
        settle_check(); chk("single_stored", a_s[1], 7); advance();

        idle(); b_se[0][2] = 1; b_se[1][2] = 1; b_wa[0] = 2; b_wa[1] = 2; b_wi[0][2] = 1; b_wi[1][2] = 1;
        b_ws[0][2] = 5'd3; b_ws[1][2] = 5'b11110; b_ra = 2; b_ri[2] = 1;
        settle_check(); chk("collide_bypass", a_s[2], 30); advance();
        idle(); b_ra = 2; b_ri[2] = 1;
        settle_check(); chk("collide_stored", a_s[2], 30); advance();

        idle(); b_se[0][0] = 1; b_wa[0] = 4; b_wi[0][0] = 1; b_ws[0][0] = 5'd5;
        b_se[1][1] = 1; b_wa[1] = 4; b_wi[1][1] = 2; b_ws[1][1] = 5'd4;
        settle_check(); advance();
        idle(); b_ce[0] = 1; b_wa[0] = 4; b_se[1][0] = 1; b_te[1][0] = 1; b_wa[1] = 4;
        b_ws[1][0] = 5'd9; b_wt[1][0] = 3'b011; b_ra = 4;
        settle_check(); chk("clr_sp_stat_byp", a_s[0], 0); chk("clr_sp_trend_byp", a_t[0], 3); advance();
        idle(); b_ra = 4; b_ri[0] = 1; b_ri[1] = 2;
        settle_check(); chk("clr_sp1_stat", a_s[0], 0); chk("clr_lhp2_stat", a_s[1], 0); advance();
        idle(); b_ra = 4;
        settle_check(); chk("clr_sp_trend", a_t[0], 3); advance();

        idle(); b_wa[0] = 6; b_wa[1] = 6; b_ra = 6;
        for (int p = 0; p < 3; p++) begin b_se[0][p] = 1; b_te[1][p] = 1; end
        b_ws[0][0] = 5'd6; b_ws[0][1] = 5'd6; b_ws[0][2] = 5'd2;
        b_wt[1][0] = 3'd1; b_wt[1][1] = 3'd2; b_wt[1][2] = 3'd0;
        settle_check(); chk("chooser_lhp_byp", a_sel, 1); advance();
        idle(); b_ra = 6;
        settle_check(); chk("chooser_lhp", a_sel, 1); advance();
        idle(); b_wa[0] = 6; b_wa[1] = 6; b_ra = 6;
        for (int p = 0; p < 3; p++) begin
            b_se[0][p] = 1; b_te[1][p] = 1; b_ws[0][p] = 5'd3; b_wt[1][p] = 3'd1;
        end
        settle_check(); chk("chooser_tie", a_sel, 2); advance();

        for (int a = 0; a < 8; a += 2) begin
            idle(); b_se[0][1] = 1; b_wa[0] = 3'(a); b_ws[0][1] = 5'(a + 1);
            b_se[1][1] = 1; b_wa[1] = 3'(a + 1); b_ws[1][1] = 5'(a + 2);
            settle_check(); advance();
        end
        idle(); b_ce[0] = 1; b_wa[0] = 0; b_ce[1] = 1; b_wa[1] = 7;
        settle_check(); chk("dual_clr_byp", a_s[1], 0); advance();
        for (int a = 0; a < 8; a++) begin
            idle(); b_ra = 3'(a);
            settle_check(); chk($sformatf("dual_clr_addr%0d", a), a_s[1], (a == 0 || a == 7) ? 0 : a + 1);
            advance();
        end

        repeat (300) begin rand_in(); settle_check(); advance(); end

        rand_in();
        #2;
        rst = 1'b1;
        #1;
        reset_outputs_chk("rst_async");
        zero_model();
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        b_ra = 3'($urandom_range(0, 7));
        settle_check();
        chk("post_rst2_sel", a_sel, 2);
        advance();

        repeat (300) begin rand_in(); settle_check(); advance(); end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
